fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences an in-place radix-2 DIT FFT of 2^N_LOG2 points over all stages.
//  For each butterfly it issues the twiddle ROM address and the operand RAM addresses.
//  The real and imaginary twiddle ROMs share one address and have a registered read (1-cycle latency).
//  Butterfly issue is delayed to align with the ROM data; the block drains the butterfly pipeline between stages.
//  Sits between the CWT top-level control (start/done) and the twiddle ROMs, data RAM and butterfly unit.
// PARAMETERS
//  N_LOG2    4  log2 of FFT size; N/2 = 2^(N_LOG2-1) butterflies per stage
//  ROM_AW    5  twiddle ROM address width; must satisfy 2^ROM_AW >= N_LOG2*N/2
//  ROM_LAT   1  twiddle ROM read latency in cycles
//  BFLY_LAT  3  butterfly unit latency, from issue to RAM write-back
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous, active-low reset
//  start       in   1         one-cycle request to start a transform; sampled only in IDLE
//  busy        out  1         high from the cycle after start is accepted until done
//  done        out  1         one-cycle pulse when the last stage has drained
//  tw_addr     out  ROM_AW    twiddle ROM address (drives both the real and imaginary ROMs)
//  bfly_valid  out  1         operand addresses are valid and ROM data is aligned
//  bfly_ready  in   1         butterfly unit accepts the issue when bfly_valid && bfly_ready
//  op_a_addr   out  N_LOG2    top operand RAM address
//  op_b_addr   out  N_LOG2    bottom operand RAM address
//  stage       out  N_LOG2    current stage index (for scaling control)
//  last_bfly   out  1         qualifies bfly_valid: last butterfly of the transform
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE. Reset is asynchronous at any time, including mid-transform.
//    After reset the block returns to IDLE. No done pulse is produced. Any partial transform is discarded.
//  FSM states and transitions:
//    IDLE:  on start, go to ISSUE with s=0, k=0, busy=1.
//    ISSUE: generate one butterfly per advance. After k=N/2-1 is accepted, go to DRAIN.
//    DRAIN: count ROM_LAT+BFLY_LAT cycles, then:
//      if s < N_LOG2-1: s++, k=0, return to ISSUE;
//      otherwise: go to IDLE, busy=0, done=1 for one cycle.
//  Addressing for stage s, butterfly k:
//    span = 2^s; grp = k>>s; pos = k & (span-1)
//    a = grp*2*span + pos; b = a + span (both mod N)
//    tw_addr = s*(N/2) + k, computed to ROM_AW bits, no wrap
//  Pipeline: tw_addr is registered. Operand addresses, stage and last_bfly are delayed by ROM_LAT stages.
//    bfly_valid therefore coincides with the ROM data for that tw_addr.
//  Advance condition: adv = !bfly_valid || bfly_ready.
//    When adv=0, tw_addr, the delay stages and the counters all hold.
//    The ROM re-reads the held address, so its data stays stable.
//  start while busy=1 is ignored. start in the same cycle as done is ignored; it must be re-asserted.
//  bfly_ready is ignored while bfly_valid=0.
//  DRAIN count begins on the cycle after the final issue of the stage is accepted.
// STRUCTURE
//  Shared package fft_ctrl_pkg:
//    state enum {IDLE, ISSUE, DRAIN}
//    FFT_N_LOG2 and TW_ROM_AW constants
//    drain-count width function
//  Sub-module fft_bfly_addr_gen: combinational (s,k) -> (a, b, tw_addr).
//    Reused by the inverse-FFT path.
//  Top level contains: FSM, k/s/drain counters, ROM_LAT-deep alignment shift register with hold.
// TESTING (N_LOG2=4, ROM_AW=5, ROM_LAT=1, BFLY_LAT=3, twiddle ROMs instantiated)
//  1. start pulse, bfly_ready=1:
//     exactly 32 bfly_valid cycles; busy high for 48 cycles; one done pulse as busy falls.
//  2. Address check:
//     s=0,k=0 -> a=0,b=1,tw=0.
//     s=1,k=3 -> a=5,b=7,tw=11.
//     s=3,k=7 -> a=7,b=15,tw=31, last_bfly=1.
//  3. Stall: drop bfly_ready for 5 cycles at s=2,k=4.
//     bfly_valid, addresses and ROM data are held stable.
//     No butterfly is lost or duplicated; busy extends by 5 cycles.
//  4. start pulses at cycle 10 and in the done cycle are ignored; busy and counts are unchanged.
//  5. Assert rst_n=0 mid-stage 2:
//     all outputs are 0 asynchronously, no done pulse.
//     A following start runs a clean 32-butterfly transform.
//  6. Random bfly_ready (50%): the scoreboard matches the issued (a,b,tw) sequence to the reference model.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for the FFT sequencing blocks.
//   fft_state_e      : sequencer FSM states
//   FFT_N_LOG2       : default log2 of the transform size
//   TW_ROM_AW        : default twiddle ROM address width
//   drain_cnt_width  : bits needed to count 0..cycles-1 in the drain phase
package fft_ctrl_pkg;

    localparam int FFT_N_LOG2 = 4;
    localparam int TW_ROM_AW  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fft_state_e;

    function automatic int drain_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational radix-2 DIT butterfly addressing for stage s, butterfly k.
// Shared with the inverse-FFT path.
//   i_s   : stage index
//   i_k   : butterfly index within the stage (0 .. N/2-1)
//   o_a   : top operand address     = (k>>s)*2*2^s + (k & (2^s-1)), mod N
//   o_b   : bottom operand address  = o_a + 2^s, mod N
//   o_tw  : twiddle ROM address     = s*(N/2) + k
module fft_bfly_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int ROM_AW = TW_ROM_AW
) (
    input  logic [N_LOG2-1:0] i_s,
    input  logic [N_LOG2-2:0] i_k,
    output logic [N_LOG2-1:0] o_a,
    output logic [N_LOG2-1:0] o_b,
    output logic [ROM_AW-1:0] o_tw
);

    logic [N_LOG2-1:0] w_k;
    logic [N_LOG2-1:0] w_span;
    logic [N_LOG2-1:0] w_pos;
    logic [N_LOG2-1:0] w_grp;

    assign w_k    = {1'b0, i_k};
    assign w_span = N_LOG2'(1) << i_s;
    assign w_pos  = w_k & (w_span - N_LOG2'(1));
    assign w_grp  = w_k >> i_s;

    // Working at N_LOG2 bits gives the mod-N wrap for free.
    assign o_a  = (w_grp << (i_s + N_LOG2'(1))) + w_pos;
    assign o_b  = o_a + w_span;
    assign o_tw = (ROM_AW'(i_s) << (N_LOG2 - 1)) + ROM_AW'(i_k);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences an in-place radix-2 DIT FFT over all stages: issues twiddle ROM
// addresses and operand RAM addresses, aligns the operand issue with the
// registered ROM read, and drains the butterfly pipeline between stages.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : start request, accepted only in IDLE and not in the done cycle
//   busy        : transform in progress
//   done        : one-cycle pulse when the last stage has drained
//   tw_addr     : twiddle ROM address (real and imaginary ROMs)
//   bfly_valid  : operand addresses valid, ROM data aligned
//   bfly_ready  : butterfly unit accepts when bfly_valid && bfly_ready
//   op_a_addr   : top operand address
//   op_b_addr   : bottom operand address
//   stage       : stage index of the presented butterfly
//   last_bfly   : presented butterfly is the last of the transform
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int N_LOG2   = FFT_N_LOG2,
    parameter int ROM_AW   = TW_ROM_AW,
    parameter int ROM_LAT  = 1,
    parameter int BFLY_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] tw_addr,
    output logic              bfly_valid,
    input  logic              bfly_ready,
    output logic [N_LOG2-1:0] op_a_addr,
    output logic [N_LOG2-1:0] op_b_addr,
    output logic [N_LOG2-1:0] stage,
    output logic              last_bfly
);

    localparam int HALF      = 1 << (N_LOG2 - 1);
    localparam int KW        = N_LOG2 - 1;
    localparam int DRAIN_CYC = ROM_LAT + BFLY_LAT;
    localparam int DW        = drain_cnt_width(DRAIN_CYC);

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [N_LOG2-1:0] stage;
        logic [N_LOG2-1:0] a;
        logic [N_LOG2-1:0] b;
        logic [ROM_AW-1:0] tw;
    } issue_t;

    fft_state_e        r_state;
    fft_state_e        w_state_nxt;
    logic [N_LOG2-1:0] r_s;
    logic [KW-1:0]     r_k;
    logic [DW-1:0]     r_drain;
    logic              r_done;
    issue_t            r_iss;              // issue register, same cycle as the registered tw address
    issue_t            r_align [ROM_LAT];  // delays operands to meet the ROM data

    logic [N_LOG2-1:0] w_a;
    logic [N_LOG2-1:0] w_b;
    logic [ROM_AW-1:0] w_tw;
    issue_t            w_out;
    logic              w_adv;
    logic              w_issue;
    logic              w_k_last;
    logic              w_s_last;
    logic              w_drain_last;
    logic              w_start_ok;

    fft_bfly_addr_gen #(
        .N_LOG2 (N_LOG2),
        .ROM_AW (ROM_AW)
    ) u_addr_gen (
        .i_s  (r_s),
        .i_k  (r_k),
        .o_a  (w_a),
        .o_b  (w_b),
        .o_tw (w_tw)
    );

    assign w_out        = r_align[ROM_LAT-1];
    assign w_adv        = !w_out.valid || bfly_ready;
    assign w_issue      = (r_state == ISSUE);
    assign w_k_last     = (r_k == KW'(HALF - 1));
    assign w_s_last     = (r_s == N_LOG2'(N_LOG2 - 1));
    assign w_drain_last = (r_drain == DW'(DRAIN_CYC - 1));
    // A start coinciding with done is dropped; the requester must re-assert it.
    assign w_start_ok   = start && !r_done;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = ISSUE;
            ISSUE:   if (w_adv && w_k_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_adv && w_drain_last) w_state_nxt = w_s_last ? IDLE : ISSUE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Stage/butterfly/drain counters; all hold while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_k     <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_adv && w_drain_last && w_s_last;
            unique case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_s     <= '0;
                        r_k     <= '0;
                        r_drain <= '0;
                    end
                end
                ISSUE: begin
                    // k wraps to 0 naturally after the last butterfly of the stage.
                    if (w_adv) r_k <= r_k + KW'(1);
                end
                DRAIN: begin
                    if (w_adv) begin
                        if (w_drain_last) begin
                            r_drain <= '0;
                            if (!w_s_last) r_s <= r_s + N_LOG2'(1);
                        end else begin
                            r_drain <= r_drain + DW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Issue register plus alignment shift register. Payload fields load only
    // on a real issue so outputs stay quiet between butterflies.
    // NOTE: these pipeline registers are reset (unlike a data memory) because
    // they drive module outputs that must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss <= '0;
            for (int i = 0; i < ROM_LAT; i++) r_align[i] <= '0;
        end else if (w_adv) begin
            r_iss.valid <= w_issue;
            if (w_issue) begin
                r_iss.last  <= w_k_last && w_s_last;
                r_iss.stage <= r_s;
                r_iss.a     <= w_a;
                r_iss.b     <= w_b;
                r_iss.tw    <= w_tw;
            end
            r_align[0] <= r_iss;
            for (int i = 1; i < ROM_LAT; i++) r_align[i] <= r_align[i-1];
        end
    end

    // While stalled the ROM must keep reading the presented butterfly's
    // twiddle, not the already-issued next one, so its data stays stable.
    assign tw_addr    = w_adv ? r_iss.tw : w_out.tw;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign bfly_valid = w_out.valid;
    assign op_a_addr  = w_out.a;
    assign op_b_addr  = w_out.b;
    assign stage      = w_out.stage;
    assign last_bfly  = w_out.valid && w_out.last;

endmodule
